// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage of the sequential Y86-64 core.
// Takes icode/valE/valA/valP from execute and moves one 8-byte word, one byte
// per beat (little-endian), over a request/grant data bus. It then reports
// valM and a Y86 status code with a single-cycle done pulse.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   start_i                one-cycle pulse, latches icode_i/valE_i/valA_i/valP_i
//   icode_i, valE_i,
//   valA_i, valP_i         instruction code and operand values
//   busy_o, done_o         transfer in progress / one-cycle completion pulse
//   valM_o, stat_o         loaded word and status (1 AOK, 2 HLT, 3 ADR, 4 INS)
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o  registered beat request, held until granted
//   mem_gnt_i, mem_rvalid_i,
//   mem_rdata_i, mem_err_i   grant, read-data return and beat error
module mem_access_stage #(
  parameter int unsigned MEM_BYTES = 8192
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  icode_i,
  input  logic [63:0] valE_i,
  input  logic [63:0] valA_i,
  input  logic [63:0] valP_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] valM_o,
  output logic [2:0]  stat_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [7:0]  mem_rdata_i,
  input  logic        mem_err_i
);

  localparam logic [2:0]  STAT_AOK  = 3'd1;
  localparam logic [2:0]  STAT_HLT  = 3'd2;
  localparam logic [2:0]  STAT_ADR  = 3'd3;
  localparam logic [2:0]  STAT_INS  = 3'd4;
  localparam logic [63:0] LAST_BASE = 64'(MEM_BYTES) - 64'd8;

  typedef enum logic [1:0] {IDLE, REQ, RWAIT, DONE} state_t;

  state_t      state;
  logic [63:0] base;
  logic [2:0]  beat;
  logic [2:0]  beat_nx;
  logic        is_write;
  // Shared byte shifter: writes shift bytes 1..7 out of the low end, reads
  // shift received bytes 0..6 in at the top so byte 0 lands in [7:0].
  logic [55:0] shift;

  logic        dec_access;
  logic        dec_write;
  logic [63:0] dec_base;
  logic [63:0] dec_data;
  logic [2:0]  dec_stat;

  assign beat_nx = beat + 3'd1;

  always_comb begin
    dec_access = 1'b0;
    dec_write  = 1'b0;
    dec_base   = valE_i;
    dec_data   = valA_i;
    dec_stat   = STAT_AOK;
    case (icode_i)
      4'h4, 4'hA: begin
        dec_access = 1'b1;
        dec_write  = 1'b1;
      end
      4'h8: begin
        dec_access = 1'b1;
        dec_write  = 1'b1;
        dec_data   = valP_i;
      end
      4'h5: dec_access = 1'b1;
      4'h9, 4'hB: begin
        dec_access = 1'b1;
        dec_base   = valA_i;
      end
      4'h0: dec_stat = STAT_HLT;
      4'h1, 4'h2, 4'h3, 4'h6, 4'h7: dec_stat = STAT_AOK;
      default: dec_stat = STAT_INS;
    endcase
    // Any base past the last full word is rejected before a beat is issued,
    // which also rules out 64-bit wrap of base + beat.
    if (dec_access && (dec_base > LAST_BASE)) begin
      dec_access = 1'b0;
      dec_stat   = STAT_ADR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      valM_o      <= '0;
      stat_o      <= STAT_AOK;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      base        <= '0;
      beat        <= '0;
      is_write    <= 1'b0;
      shift       <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            base     <= dec_base;
            beat     <= '0;
            is_write <= dec_write;
            if (dec_access) begin
              state       <= REQ;
              busy_o      <= 1'b1;
              mem_req_o   <= 1'b1;
              mem_we_o    <= dec_write;
              mem_addr_o  <= dec_base;
              mem_wdata_o <= dec_write ? dec_data[7:0] : '0;
              shift       <= dec_write ? dec_data[63:8] : '0;
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
              valM_o <= '0;
              stat_o <= dec_stat;
            end
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            if (!is_write) begin
              mem_req_o <= 1'b0;
              state     <= RWAIT;
            end else if (mem_err_i || (beat == 3'd7)) begin
              state     <= DONE;
              done_o    <= 1'b1;
              busy_o    <= 1'b0;
              mem_req_o <= 1'b0;
              mem_we_o  <= 1'b0;
              valM_o    <= '0;
              stat_o    <= mem_err_i ? STAT_ADR : STAT_AOK;
            end else begin
              beat        <= beat_nx;
              mem_addr_o  <= base + {61'd0, beat_nx};
              mem_wdata_o <= shift[7:0];
              shift       <= {8'd0, shift[55:8]};
            end
          end
        end
        RWAIT: begin
          if (mem_rvalid_i) begin
            if (mem_err_i || (beat == 3'd7)) begin
              state    <= DONE;
              done_o   <= 1'b1;
              busy_o   <= 1'b0;
              mem_we_o <= 1'b0;
              valM_o   <= mem_err_i ? '0 : {mem_rdata_i, shift};
              stat_o   <= mem_err_i ? STAT_ADR : STAT_AOK;
            end else begin
              shift      <= {mem_rdata_i, shift[55:8]};
              beat       <= beat_nx;
              mem_addr_o <= base + {61'd0, beat_nx};
              mem_req_o  <= 1'b1;
              state      <= REQ;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes expected bus beats
// and completion responses; separate monitors pop and compare them.
module tb_mem_access_stage;
  localparam int unsigned MEM_BYTES = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  icode = '0;
  logic [63:0] valE = '0, valA = '0, valP = '0;
  logic        busy, done, mem_req, mem_we;
  logic [63:0] valM, mem_addr;
  logic [2:0]  stat;
  logic [7:0]  mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
  logic [7:0]  mem_rdata = '0;

  mem_access_stage #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .icode_i(icode),
    .valE_i(valE), .valA_i(valA), .valP_i(valP),
    .busy_o(busy), .done_o(done), .valM_o(valM), .stat_o(stat),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .mem_err_i(mem_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [63:0] addr; logic we; logic [7:0] wdata;} beat_t;
  typedef struct {logic [63:0] valm; logic [2:0] stat; int unsigned lat;} resp_t;
  beat_t exp_beats[$];
  resp_t exp_resp[$];

  int total = 0;
  int bad = 0;
  int unsigned t_start = 0;

  // Bus responder configuration
  int beat_n = 0;
  int stall_beat = -1;
  int stall_left = 0;
  int err_beat = -1;
  logic rd_pend = 1'b0;
  int rd_beat = 0;
  logic [7:0] rd_bytes [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Responder: grant on request (optionally stalling one beat), return read
  // data one cycle after the grant, raise err on a chosen beat.
  initial forever begin
    @(negedge clk);
    if (rd_pend) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rd_bytes[rd_beat];
      mem_err    = (rd_beat == err_beat);
      rd_pend    = 1'b0;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 8'hXX;
      mem_err    = 1'b0;
    end
    mem_gnt = 1'b0;
    if (mem_req && !rst) begin
      if (beat_n == stall_beat && stall_left > 0) begin
        stall_left--;
        if (exp_beats.size() > 0) begin
          check("stall_addr", mem_addr, exp_beats[0].addr);
          check("stall_we", 64'(mem_we), 64'(exp_beats[0].we));
          check("stall_wdata", 64'(mem_wdata), 64'(exp_beats[0].wdata));
        end
      end else begin
        mem_gnt = 1'b1;
        if (mem_we) mem_err = (beat_n == err_beat);
        else begin
          rd_pend = 1'b1;
          rd_beat = beat_n;
        end
        beat_n++;
      end
    end
  end

  // Beat monitor
  initial forever begin
    beat_t b;
    @(negedge clk); #1;
    if (mem_req && mem_gnt) begin
      if (exp_beats.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_beat: got addr %h we %b, expected no beat", mem_addr, mem_we);
      end else begin
        b = exp_beats.pop_front();
        check("beat_addr", mem_addr, b.addr);
        check("beat_we", 64'(mem_we), 64'(b.we));
        if (b.we) check("beat_wdata", 64'(mem_wdata), 64'(b.wdata));
      end
    end
  end

  // Completion monitor
  initial forever begin
    resp_t r;
    @(negedge clk); #1;
    if (done) begin
      if (exp_resp.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got stat %0d valM %h, expected no done", stat, valM);
      end else begin
        r = exp_resp.pop_front();
        check("valM", valM, r.valm);
        check("stat", 64'(stat), 64'(r.stat));
        check("latency", 64'(cyc - t_start), 64'(r.lat));
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic issue(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p);
    icode = ic; valE = e; valA = a; valP = p;
    start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stray_start(input logic [3:0] ic);
    icode = ic;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_write(input logic [63:0] b, input logic [63:0] d, input int n);
    for (int i = 0; i < n; i++) exp_beats.push_back('{b + 64'(i), 1'b1, d[8*i +: 8]});
  endtask

  task automatic push_read(input logic [63:0] b, input int n);
    for (int i = 0; i < n; i++) exp_beats.push_back('{b + 64'(i), 1'b0, 8'h00});
  endtask

  task automatic push_resp(input logic [63:0] v, input logic [2:0] s, input int unsigned l);
    exp_resp.push_back('{v, s, l});
  endtask

  // Leaves the caller at the negedge of the done cycle.
  task automatic wait_done(input string name);
    int unsigned k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no done_o, expected one within 200 cycles", name);
    end
  endtask

  task automatic cfg_bus(input int sb, input int sl, input int eb);
    beat_n = 0; stall_beat = sb; stall_left = sl; err_beat = eb;
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_busy"}, 64'(busy), 64'd0);
    check({p, "_done"}, 64'(done), 64'd0);
    check({p, "_req"}, 64'(mem_req), 64'd0);
    check({p, "_we"}, 64'(mem_we), 64'd0);
    check({p, "_addr"}, mem_addr, 64'd0);
    check({p, "_wdata"}, 64'(mem_wdata), 64'd0);
    check({p, "_valM"}, valM, 64'd0);
    check({p, "_stat"}, 64'(stat), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1);
  end

  initial begin
    rd_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // pushq: 8 zero-wait write beats; stray starts while busy and on done ignored
    cfg_bus(-1, 0, -1);
    push_write(64'h100, 64'h0807060504030201, 8);
    push_resp(64'd0, 3'd1, 9);
    issue(4'hA, 64'h100, 64'h0807060504030201, 64'h0);
    check("busy_after_start", 64'(busy), 64'd1);
    repeat (2) @(negedge clk);
    stray_start(4'h0);
    wait_done("pushq");
    stray_start(4'h0);
    repeat (3) @(negedge clk);

    // mrmovq: read with rvalid one cycle after each grant
    cfg_bus(-1, 0, -1);
    push_read(64'h20, 8);
    push_resp(64'h12345678DEADBEEF, 3'd1, 17);
    issue(4'h5, 64'h20, 64'h0, 64'h0);
    wait_done("mrmovq");
    @(negedge clk);

    // rmmovq: beat 2 stalled 3 cycles, error on beat 5 -> no beats 6..7
    cfg_bus(2, 3, 5);
    push_write(64'h200, 64'hF0E0D0C0B0A09080, 6);
    push_resp(64'd0, 3'd3, 10);
    issue(4'h4, 64'h200, 64'hF0E0D0C0B0A09080, 64'h0);
    wait_done("rmmovq_err");
    @(negedge clk);
    cfg_bus(-1, 0, -1);

    // popq beyond the last word; halt, INS, OPq: no bus activity
    push_resp(64'd0, 3'd3, 1);
    issue(4'hB, 64'h0, 64'(MEM_BYTES - 4), 64'h0);
    wait_done("popq_adr");
    @(negedge clk);
    push_resp(64'd0, 3'd2, 1);
    issue(4'h0, 64'h100, 64'h100, 64'h0);
    wait_done("halt");
    @(negedge clk);
    push_resp(64'd0, 3'd4, 1);
    issue(4'hD, 64'h100, 64'h100, 64'h0);
    wait_done("ins");
    @(negedge clk);
    push_resp(64'd0, 3'd1, 1);
    issue(4'h6, 64'h100, 64'h100, 64'h0);
    wait_done("opq");
    @(negedge clk);

    // Bounds edge: last full word accepted, one byte further rejected
    push_write(64'(MEM_BYTES - 8), 64'h1122334455667788, 8);
    push_resp(64'd0, 3'd1, 9);
    issue(4'h4, 64'(MEM_BYTES - 8), 64'h1122334455667788, 64'h0);
    wait_done("rmmovq_last");
    @(negedge clk);
    push_resp(64'd0, 3'd3, 1);
    issue(4'h4, 64'(MEM_BYTES - 7), 64'h1122334455667788, 64'h0);
    wait_done("rmmovq_over");
    @(negedge clk);

    // Load a nonzero valM so the reset check below is meaningful
    cfg_bus(-1, 0, -1);
    push_read(64'h20, 8);
    push_resp(64'h12345678DEADBEEF, 3'd1, 17);
    issue(4'h5, 64'h20, 64'h0, 64'h0);
    wait_done("mrmovq2");
    @(negedge clk);

    // Read aborted by reset while beat 4 is requested
    cfg_bus(4, 1000, -1);
    push_read(64'h40, 4);
    issue(4'h5, 64'h40, 64'h0, 64'h0);
    begin
      int unsigned k = 0;
      #2;
      while (!(beat_n == 4 && mem_req && !mem_gnt) && k < 100) begin
        @(negedge clk); #2;
        k++;
      end
      check("reached_beat4", 64'(beat_n), 64'd4);
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midreset");
    rst = 1'b0;
    cfg_bus(-1, 0, -1);
    check("beats_flushed", 64'(exp_beats.size()), 64'd0);
    @(negedge clk);

    // call after the abort writes valP
    push_write(64'h300, 64'h55, 8);
    push_resp(64'd0, 3'd1, 9);
    issue(4'h8, 64'h300, 64'hDEAD, 64'h55);
    wait_done("call");
    repeat (5) @(negedge clk);

    check("beats_left", 64'(exp_beats.size()), 64'd0);
    check("resp_left", 64'(exp_resp.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the sequential Y86-64 core, downstream of the execute stage.
- Consumes icode, valE (ALU result), valA and valP; performs the 8-byte data-memory read or write the instruction requires over a byte-wide request/grant bus.
- Returns valM and a Y86 status code.
- Multi-cycle: the control sequencer pulses start_i and waits for done_o.

Parameters:
- MEM_BYTES, 8192, size of data memory in bytes; valid addresses are 0..MEM_BYTES-1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- start_i  in  1  one-cycle pulse; latch icode_i, valE_i, valA_i, valP_i
- icode_i  in  4  instruction code
- valE_i  in  64  execute-stage result
- valA_i  in  64  register A value
- valP_i  in  64  incremented PC
- busy_o  out  1  high from the cycle after an accepted start until done_o
- done_o  out  1  one-cycle completion pulse
- valM_o  out  64  loaded word; held until next done_o
- stat_o  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS; held until next done_o
- mem_req_o  out  1  beat request
- mem_we_o  out  1  1=write beat
- mem_addr_o  out  64  byte address of current beat
- mem_wdata_o  out  8  write byte
- mem_gnt_i  in  1  beat accepted when mem_req_o & mem_gnt_i
- mem_rvalid_i  in  1  read byte valid; ≥1 cycle after the grant
- mem_rdata_i  in  8  read byte
- mem_err_i  in  1  beat error; sampled with gnt for writes and with rvalid for reads

Behaviour:
- Reset (rst_i high at posedge): state IDLE.
  - busy_o=0, done_o=0, mem_req_o=0, mem_we_o=0.
  - mem_addr_o=0, mem_wdata_o=0, valM_o=0, stat_o=1 (AOK).
  - beat counter=0.
  - Reset mid-transfer aborts immediately; no done_o is produced.
- Start acceptance: start_i is honoured only in IDLE and ignored while busy_o=1.
- Operation decode from the latched icode:
  - 4 (rmmovq): write valA to address valE.
  - 8 (call): write valP to address valE.
  - A (pushq): write valA to address valE.
  - 5 (mrmovq): read from address valE.
  - 9 (ret) and B (popq): read from address valA.
  - 0 (halt): no access, stat=HLT.
  - 1, 2, 3, 6, 7 (nop, cmovXX, irmovq, OPq, jXX): no access, stat=AOK.
  - C–F: no access, stat=INS.
- No-access and bounds-failure case: done_o pulses the cycle after start with valM_o=0. A bounds failure means base address > MEM_BYTES-8 (unsigned 64-bit compare); it reports stat=ADR and issues no bus beats.
- FSM states: IDLE → REQ → (read: RWAIT → REQ…) → DONE → IDLE.
  - REQ: mem_req_o=1 with address = base + beat (beat 0..7, little-endian).
    - mem_wdata_o = byte[beat] of the latched data.
    - mem_req_o, mem_addr_o, mem_we_o and mem_wdata_o are registered and held stable until granted.
  - Write grant: advance the beat. After beat 7 go to DONE.
  - Read grant: drop mem_req_o and go to RWAIT. On mem_rvalid_i, store the byte into valM bits [8*beat+7:8*beat] and advance the beat. After beat 7 go to DONE, otherwise return to REQ.
  - mem_err_i on any beat: abort the remaining beats, go to DONE with stat=ADR and valM_o=0.
  - DONE: done_o=1 for one cycle; valM_o and stat_o update in the same cycle; busy_o=0; return to IDLE.
- Latency with zero-wait memory:
  - Write: done 9 cycles after start (8 grant cycles + DONE).
  - Read with rvalid one cycle after grant: done 17 cycles after start.
- mem_rvalid_i outside RWAIT is ignored.
- start_i asserted in the same cycle as done_o is ignored; the FSM is not yet in IDLE.
- Address arithmetic is 64-bit wrap-around, but the bounds check guarantees no wrap occurs.

Test Plan:
- Reset, then pushq with valE=0x100, valA=0x0807060504030201, gnt tied 1 → beats at addresses 0x100..0x107 carry bytes 01..08 with we=1; done_o at cycle 9; stat=1.
- mrmovq with valE=0x20; memory model returns bytes EF,BE,AD,DE,78,56,34,12 with rvalid 1 cycle after grant → valM_o=0x12345678DEADBEEF, stat=1, done at cycle 17.
- popq with valA=MEM_BYTES-4 → no mem_req_o; done the next cycle; stat=3; valM_o=0.
- halt → done next cycle, stat=2; icode 0xD → stat=4; OPq → stat=1; no bus activity in any of these.
- Write with gnt stalled 3 cycles on beat 2 (address, data and we held stable), then mem_err_i on beat 5 → beats 6–7 not issued; stat=3.
- rst_i asserted during beat 4 of a read → next cycle all outputs at reset values; a subsequent call with valP=0x55 writes 55,00,00,00,00,00,00,00 correctly.
